// File: rtl/mul_share_pkg.sv
// Shared types and default sizing for the shared-multiplier controller.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Round-robin search starting at ptr, wrapping N-1 -> 0; one-hot grant plus index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[(int'(ptr) + k) % N]) begin
                found                         = 1'b1;
                grant[(int'(ptr) + k) % N]    = 1'b1;
                grant_idx                     = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// One multiplier shared by N_REQ requesters: arbitrate in IDLE, multiply in MUL, hold result in RESP.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    input  logic [N_REQ-1:0]           req_signed,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]         rsp_p
);
    localparam int IW = $clog2(N_REQ);

    state_t                   state;
    logic [IW-1:0]            rr_ptr;
    logic [N_REQ-1:0]         grant;
    logic [IW-1:0]            grant_idx;
    logic                     accept;
    logic [IW-1:0]            next_ptr;
    logic [WIDTH-1:0]         a_p0;
    logic [WIDTH-1:0]         b_p0;
    logic                     sgn_p0;
    logic [IW-1:0]            id_p0;
    logic signed [2*WIDTH-1:0] prod_p1;

    // Sign- or zero-extend both operands to 2*WIDTH; the low 2*WIDTH bits of the
    // extended product are exact for either interpretation, including -2^(W-1)^2.
    function automatic logic signed [2*WIDTH-1:0] mul_ext(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = sgn ? signed'({{WIDTH{a[WIDTH-1]}}, a}) : signed'({{WIDTH{1'b0}}, a});
        eb = sgn ? signed'({{WIDTH{b[WIDTH-1]}}, b}) : signed'({{WIDTH{1'b0}}, b});
        return ea * eb;
    endfunction

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is the combinational grant, forced low while reset is held.
    assign req_ready = rst_n ? grant : '0;
    assign accept    = (state == IDLE) && (|req_valid);
    assign next_ptr  = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Stage p0: operands captured on the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= req_a[grant_idx*WIDTH +: WIDTH];
            b_p0   <= req_b[grant_idx*WIDTH +: WIDTH];
            sgn_p0 <= req_signed[grant_idx];
            id_p0  <= grant_idx;
        end
    end

    // Stage p1: single-cycle multiply feeding the response registers
    assign prod_p1 = mul_ext(a_p0, b_p0, sgn_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= next_ptr;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    rsp_p     <= unsigned'(prod_p1);
                    rsp_id    <= id_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
